// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial-pattern match counter with window and done/ack handshake
// Optional macro SEQ_DET_FIRST_STOP_EN: end the session at the first match.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             start,
  input  logic             abort,
  input  logic             done_ack,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic             ovl_q, ovl_d;
  logic [WIN_W-1:0] win_q, win_d, bcnt_q, bcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;

  logic [PAT_W-1:0] hist_shift, mask;
  logic [PAT_W:0]   mask_w;
  logic [LEN_W-1:0] fill_inc;
  logic [WIN_W-1:0] bcnt_inc;
  logic             hit;

  // Length is normalised once at write time so the match path sees 1..PAT_W only.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)
      return LEN_W'(1);
    else if (l > LEN_MAX)
      return LEN_MAX;
    else
      return l;
  endfunction

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    win_d      = win_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    bcnt_d     = bcnt_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;

    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    fill_inc   = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
    bcnt_inc   = bcnt_q + WIN_W'(1);
    mask_w     = ((PAT_W+1)'(1) << len_q) - (PAT_W+1)'(1);
    mask       = mask_w[PAT_W-1:0];
    hit        = (fill_inc >= len_q) && ((hist_shift & mask) == (pat_q & mask));

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = clamp_len(cfg_len);
          ovl_d = cfg_overlap;
          win_d = cfg_window;
        end
        if (start)
          state_d = S_ARM;
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          hist_d  = '0;
          fill_d  = '0;
          bcnt_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_valid) begin
          hist_d = hist_shift;
          bcnt_d = bcnt_inc;
          fill_d = (hit && !ovl_q) ? '0 : fill_inc;
          if (hit) begin
            pulse_d = 1'b1;
            if (cnt_q != CNT_MAX)
              cnt_d = cnt_q + CNT_W'(1);
          end
          if (win_q != '0 && bcnt_inc == win_q)
            state_d = S_DONE;
`ifdef SEQ_DET_FIRST_STOP_EN
          if (hit)
            state_d = S_DONE;
`else
`endif
        end
      end
      S_DONE: begin
        if (done_ack || abort)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ARM) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b0;
      win_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      win_q   <= win_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign done        = done_q;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller. Software loads a pattern, length and overlap mode, then starts a measurement session over a window of N valid input bits. The block counts pattern matches in that window and reports completion through a done/ack handshake. It sits between a register interface and a raw serial bit stream, and replaces fixed-pattern hard-coded detectors.

Parameters:
PAT_W, 8, maximum pattern width in bits (2..16)
LEN_W, 4, width of cfg_len; must hold the value PAT_W
CNT_W, 8, width of the match counter
WIN_W, 16, width of the window bit counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  configuration write strobe; accepted only in IDLE
cfg_pattern  in  PAT_W  pattern; bit[len-1] is the oldest bit, bit[0] the newest
cfg_len  in  LEN_W  pattern length; 0 is treated as 1, values above PAT_W are treated as PAT_W
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
cfg_window  in  WIN_W  number of valid bits per session; 0 = unbounded
start  in  1  single-cycle session start; honoured only in IDLE
abort  in  1  terminates the session and returns to IDLE
done_ack  in  1  clears done
bit_valid  in  1  qualifies bit_in
bit_in  in  1  serial data bit
busy  out  1  high in ARM and RUN
match_pulse  out  1  one-cycle pulse per detected match
match_count  out  CNT_W  matches counted in the current or last session
done  out  1  session complete; held high until done_ack

Behaviour:
- Reset: state=IDLE. busy=0, match_pulse=0, match_count=0, done=0. Config registers are 0: pattern 0, length treated as 1, overlap 0, window 0.
- All outputs are registered.
- States:
  - IDLE: start moves to ARM. cfg_we latches all cfg_* fields.
  - ARM (1 cycle): clears history, fill counter, bit counter and match_count, then moves to RUN. bit_valid is ignored in ARM.
  - RUN: consumes bits, counts matches and checks the window.
  - DONE: done=1. done_ack moves to IDLE with done=0 on the next cycle. match_count is held.
- cfg_we outside IDLE is ignored; the latched config is unchanged.
- start outside IDLE is ignored, including start in DONE before done_ack.
- Per consumed bit (RUN and bit_valid=1):
  - history shifts left by one; bit_in enters bit[0].
  - fill counter increments, saturating at PAT_W.
  - bit counter increments.
- Match condition: fill (after the increment) >= len, and history[len-1:0] (after the shift) == pattern[len-1:0].
- Match response, at the edge that consumes the matching bit:
  - match_pulse=1 for exactly the following cycle.
  - match_count increments, saturating at 2^CNT_W-1; match_pulse still fires when saturated.
  - If overlap=0, the fill counter resets to 0, so the next match needs len fresh bits.
- Window end: if cfg_window != 0 and the bit counter reaches cfg_window on a consuming edge, state moves to DONE at that same edge. done and the final match_pulse can be high in the same cycle.
- abort:
  - Has priority over everything in ARM and RUN: goes to IDLE next cycle with done=0. match_count is held and match_pulse is suppressed.
  - In DONE, abort behaves as done_ack.
- done_ack outside DONE has no effect.
- Reset asserted mid-session returns immediately to reset values.

Optional Feature:
SEQ_DET_FIRST_STOP_EN
- Defined: the first match in RUN also forces DONE at the same edge. match_count ends at 1 and match_pulse still fires once. A window expiring on the same bit gives the same result.
- Undefined: the session runs until window end or abort.

Test Plan:
- Pattern 0b1010, len 4, overlap 1, window 7; bits 1,0,1,0,1,0,1 on consecutive cycles -> match_pulse after the 4th and 6th bits, match_count=2, done=1 the cycle after the 7th bit; done_ack -> IDLE.
- Same stream with overlap 0 -> single pulse after the 4th bit, match_count=1, done after the 7th bit.
- Pattern 0b1, len 1, CNT_W=8, window 300, all-ones stream -> match_count saturates at 255, match_pulse keeps firing, done after bit 300.
- Pattern 0b101, len 3, window 0, bit_valid toggled every other cycle; invalid cycles carry bit_in=1 -> invalid bits ignored and matches identical to gap-free operation; abort -> IDLE next cycle, busy=0, done=0, match_count held.
- Config write with pattern 0b11 while busy -> ignored, detection still uses the old pattern; after return to IDLE the write takes effect. start while in DONE -> ignored.
- Assert reset mid-RUN between clock edges -> all outputs 0 immediately; the next start gives a clean session with match_count counting from 0.
